// File: rtl/aline_pingpong_buffer_if.sv
// A-line buffer bus: sample capture inputs plus the outgoing word stream.
// master = acquisition/downstream side, slave = the ping-pong buffer.
interface aline_pingpong_buffer_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11
);
  logic [DATA_W-1:0] sample_in;
  logic [ADDR_W-1:0] sample_pos;
  logic              acq_busy;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;

  modport master (
    output sample_in, sample_pos, acq_busy, out_ready,
    input  out_data, out_valid, out_sop, out_eop
  );

  modport slave (
    input  sample_in, sample_pos, acq_busy, out_ready,
    output out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/aline_pingpong_buffer.sv
// Ping-pong A-line buffer: captures sample_pos-indexed lines into two banks
// and replays full banks as a sop/eop word stream (valid/ready).
// Ports: ADC_data_out_clk, global_reset_n (async, low); bus (slave modport:
// sample_in/sample_pos/acq_busy in, out_data/valid/sop/eop out, out_ready in);
// line_cnt, bank_full, overrun, short_line status out; clear_flags in.
module aline_pingpong_buffer #(
  parameter int NSAMPLES = 1170,
  parameter int DATA_W   = 14,
  parameter int ADDR_W   = 11
) (
  input  logic                  ADC_data_out_clk,
  input  logic                  global_reset_n,
  aline_pingpong_buffer_if.slave bus,
  output logic [15:0]           line_cnt,
  output logic [1:0]            bank_full,
  output logic                  overrun,
  output logic                  short_line,
  input  logic                  clear_flags
);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_N    = ADDR_W'(NSAMPLES);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NSAMPLES - 1);
  localparam bit                LP_MULTI = (NSAMPLES > 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } state_t;

  logic [DATA_W-1:0] r_mem [2][2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  state_t            r_state;
  state_t            w_state_nx;

  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic              r_drop;
  logic              r_active;
  logic [15:0]       r_line_cnt;
  logic              r_overrun;
  logic              r_short;

  logic [ADDR_W-1:0] r_raddr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;

  logic              w_start;
  logic              w_in_rng;
  logic              w_drop;
  logic              w_wr;
  logic              w_done;
  logic              w_short;
  logic              w_ovr_set;
  logic [ADDR_W-1:0] w_waddr;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  logic              w_acc;
  logic              w_ren;
  logic              w_load;
  logic              w_rel;
  logic [ADDR_W-1:0] w_raddr;

  // Write side: a line that starts on a full bank is dropped until
  // acq_busy falls; the drop decision is taken only at sample 1.
  always_comb begin
    w_start   = bus.acq_busy && (bus.sample_pos == LP_ONE);
    w_in_rng  = bus.acq_busy && (bus.sample_pos != '0)
                && (bus.sample_pos <= LP_N);
    w_ovr_set = w_start && r_full[r_wr_bank];
    w_drop    = w_start ? r_full[r_wr_bank] : r_drop;
    w_wr      = w_in_rng && !w_drop;
    w_done    = w_wr && (bus.sample_pos == LP_N);
    w_short   = !bus.acq_busy && r_active;
    w_waddr   = bus.sample_pos - LP_ONE;
    w_set     = {2{w_done}} & {r_wr_bank, ~r_wr_bank};
    w_clr     = {2{w_rel}} & {r_rd_bank, ~r_rd_bank};
  end

  // Read FSM: r_q always holds the word after the one on the output,
  // so an accept can reload the output and prefetch in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_ren      = 1'b0;
    w_load     = 1'b0;
    w_rel      = 1'b0;
    w_raddr    = '0;
    w_acc      = r_valid && bus.out_ready;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nx = S_FETCH;
          w_ren      = 1'b1;
        end
      end
      S_FETCH: begin
        w_state_nx = S_STREAM;
        w_load     = 1'b1;
        w_ren      = LP_MULTI;
        w_raddr    = LP_ONE;
      end
      S_STREAM: begin
        if (w_acc) begin
          if (r_eop) begin
            w_rel      = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_load  = 1'b1;
            w_ren   = (r_raddr != LP_LAST);
            w_raddr = r_raddr + LP_ONE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge ADC_data_out_clk) begin
    if (w_wr) begin
      r_mem[r_wr_bank][w_waddr] <= bus.sample_in;
    end
    if (w_ren) begin
      r_q <= r_mem[r_rd_bank][w_raddr];
    end
  end

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_drop     <= 1'b0;
      r_active   <= 1'b0;
      r_line_cnt <= '0;
      r_overrun  <= 1'b0;
      r_short    <= 1'b0;
      r_raddr    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_done) begin
        r_wr_bank  <= ~r_wr_bank;
        r_line_cnt <= r_line_cnt + 16'd1;
      end
      if (w_rel) begin
        r_rd_bank <= ~r_rd_bank;
      end
      r_drop    <= w_start ? r_full[r_wr_bank]
                           : (bus.acq_busy && r_drop);
      r_active  <= bus.acq_busy && !w_done
                   && (w_wr || (r_active && !w_start));
      r_overrun <= w_ovr_set || (r_overrun && !clear_flags);
      r_short   <= w_short || (r_short && !clear_flags);
      if (w_ren) begin
        r_raddr <= w_raddr;
      end
      if (w_load) begin
        r_data  <= r_q;
        r_valid <= 1'b1;
        r_sop   <= (r_state == S_FETCH);
        r_eop   <= (r_raddr == LP_LAST);
      end else if (w_rel) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_sop   = r_sop;
  assign bus.out_eop   = r_eop;
  assign line_cnt      = r_line_cnt;
  assign bank_full     = r_full;
  assign overrun       = r_overrun;
  assign short_line    = r_short;
endmodule
